// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline.
// Tracks each in-flight producer in E, M and W. Uses the Tuse/Tnew method
// to decide between stalling D and steering the forwarding muxes at the
// D, E and M operand points.
module hazard_fwd_ctrl #(
  parameter int AW        = 5,
  parameter int TW        = 2,
  parameter int TUSE_NONE = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_wa,
  input  logic          d_we,
  input  logic [TW-1:0] d_tnew,
  output logic          stall,
  output logic [1:0]    fwd_d_rs,
  output logic [1:0]    fwd_d_rt,
  output logic [1:0]    fwd_e_rs,
  output logic [1:0]    fwd_e_rt,
  output logic          fwd_m_rt
);

  localparam logic [TW-1:0] TUSE_NA = TW'(TUSE_NONE);

  // D-stage mux select codes
  localparam logic [1:0] SEL_D_RF = 2'd0;
  localparam logic [1:0] SEL_D_E  = 2'd1;
  localparam logic [1:0] SEL_D_M  = 2'd2;
  localparam logic [1:0] SEL_D_W  = 2'd3;

  // E-stage mux select codes
  localparam logic [1:0] SEL_E_REG = 2'd0;
  localparam logic [1:0] SEL_E_M   = 2'd1;
  localparam logic [1:0] SEL_E_W   = 2'd2;

  // Producer state per stage
  logic [AW-1:0] e_wa, e_rs, e_rt;
  logic          e_we;
  logic [TW-1:0] e_tnew;

  logic [AW-1:0] m_wa, m_rs, m_rt;
  logic          m_we;
  logic [TW-1:0] m_tnew;

  logic [AW-1:0] w_wa;
  logic          w_we;

  // A producer matches only when it writes a non-zero register equal to r;
  // $0 is hardwired, so it must never forward or stall.
  function automatic logic reg_match(input logic we, input logic [AW-1:0] wa,
                                     input logic [AW-1:0] r);
    return we && (wa == r) && (r != '0);
  endfunction

  // Tnew counts down as the producer advances, saturating at 0.
  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // D select: the youngest matching stage wins. A match whose result is not
  // ready yet blocks every older stage, so stale data is never chosen.
  function automatic logic [1:0] sel_d(input logic e_hit, input logic e_rdy,
                                       input logic m_hit, input logic m_rdy,
                                       input logic w_hit);
    logic [1:0] s;
    s = SEL_D_RF;
    if (e_hit)      s = e_rdy ? SEL_D_E : SEL_D_RF;
    else if (m_hit) s = m_rdy ? SEL_D_M : SEL_D_RF;
    else if (w_hit) s = SEL_D_W;
    return s;
  endfunction

  // E select: same youngest-first rule over M and W.
  function automatic logic [1:0] sel_e(input logic m_hit, input logic m_rdy,
                                       input logic w_hit);
    logic [1:0] s;
    s = SEL_E_REG;
    if (m_hit)      s = m_rdy ? SEL_E_M : SEL_E_REG;
    else if (w_hit) s = SEL_E_W;
    return s;
  endfunction

  // Operand is needed too early if any in-flight producer of it needs
  // more cycles than the consumer can wait.
  function automatic logic need_stall(input logic [TW-1:0] tuse,
                                      input logic e_hit, input logic [TW-1:0] et,
                                      input logic m_hit, input logic [TW-1:0] mt);
    return (tuse != TUSE_NA) &&
           ((e_hit && (et > tuse)) || (m_hit && (mt > tuse)));
  endfunction

  logic e_hit_drs, m_hit_drs, w_hit_drs;
  logic e_hit_drt, m_hit_drt, w_hit_drt;
  logic m_hit_ers, w_hit_ers;
  logic m_hit_ert, w_hit_ert;
  logic w_hit_mrt;
  logic e_rdy, m_rdy;

  // Match detection of every consumer operand against every producer stage
  always_comb begin
    e_hit_drs = reg_match(e_we, e_wa, d_rs);
    m_hit_drs = reg_match(m_we, m_wa, d_rs);
    w_hit_drs = reg_match(w_we, w_wa, d_rs);
    e_hit_drt = reg_match(e_we, e_wa, d_rt);
    m_hit_drt = reg_match(m_we, m_wa, d_rt);
    w_hit_drt = reg_match(w_we, w_wa, d_rt);
    m_hit_ers = reg_match(m_we, m_wa, e_rs);
    w_hit_ers = reg_match(w_we, w_wa, e_rs);
    m_hit_ert = reg_match(m_we, m_wa, e_rt);
    w_hit_ert = reg_match(w_we, w_wa, e_rt);
    w_hit_mrt = reg_match(w_we, w_wa, m_rt);
    e_rdy     = (e_tnew == '0);
    m_rdy     = (m_tnew == '0);
  end

  // Stall decision and forwarding selects, all purely combinational
  always_comb begin
    stall    = need_stall(d_tuse_rs, e_hit_drs, e_tnew, m_hit_drs, m_tnew) ||
               need_stall(d_tuse_rt, e_hit_drt, e_tnew, m_hit_drt, m_tnew);
    fwd_d_rs = sel_d(e_hit_drs, e_rdy, m_hit_drs, m_rdy, w_hit_drs);
    fwd_d_rt = sel_d(e_hit_drt, e_rdy, m_hit_drt, m_rdy, w_hit_drt);
    fwd_e_rs = sel_e(m_hit_ers, m_rdy, w_hit_ers);
    fwd_e_rt = sel_e(m_hit_ert, m_rdy, w_hit_ert);
    fwd_m_rt = w_hit_mrt;
  end

  // Pipeline advance: W <= M, M <= E (aging tnew), E <= D or a bubble on stall
  always_ff @(posedge clk) begin
    if (reset) begin
      e_wa   <= '0;
      e_we   <= 1'b0;
      e_tnew <= '0;
      e_rs   <= '0;
      e_rt   <= '0;
      m_wa   <= '0;
      m_we   <= 1'b0;
      m_tnew <= '0;
      m_rs   <= '0;
      m_rt   <= '0;
      w_wa   <= '0;
      w_we   <= 1'b0;
    end else begin
      // M -> W boundary
      w_wa   <= m_wa;
      w_we   <= m_we;
      // E -> M boundary
      m_wa   <= e_wa;
      m_we   <= e_we;
      m_tnew <= tnew_dec(e_tnew);
      m_rs   <= e_rs;
      m_rt   <= e_rt;
      // D -> E boundary
      if (stall) begin
        e_wa   <= '0;
        e_we   <= 1'b0;
        e_tnew <= '0;
        e_rs   <= '0;
        e_rt   <= '0;
      end else begin
        e_wa   <= d_wa;
        e_we   <= d_we;
        e_tnew <= d_tnew;
        e_rs   <= d_rs;
        e_rt   <= d_rt;
      end
    end
  end

  // m_rs is carried for pipeline completeness; M has no rs operand point.
  logic unused_m_rs;
  assign unused_m_rs = ^m_rs;

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined MIPS core.
- Tracks destination register, write-enable and Tnew for each instruction in the E, M and W stages.
- Drives the select lines of the forwarding 2:1 mux chains at the D, E and M operand points, and drives the D-stage stall.
- Uses the Tuse/Tnew method: stall when Tuse < Tnew; otherwise forward from the youngest producer that has its result ready.

Parameters:
- AW, 5, register address width.
- TW, 2, width of Tuse/Tnew fields.
- TUSE_NONE, 3, Tuse code meaning "operand not read".

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- d_rs  input  AW  rs of the instruction in D.
- d_rt  input  AW  rt of the instruction in D.
- d_tuse_rs  input  TW  cycles from D until rs is consumed (0 = branch/jr, 1 = ALU, 2 = store data); TUSE_NONE = not read.
- d_tuse_rt  input  TW  same, for rt.
- d_wa  input  AW  destination register of the D instruction.
- d_we  input  1  D instruction writes the register file.
- d_tnew  input  TW  cycles after entering E until the result is ready (jal/lui = 0, ALU = 1, load = 2).
- stall  output  1  freeze PC and the F/D register; insert a bubble into E.
- fwd_d_rs  output  2  D rs source: 0 = RF, 1 = E, 2 = M, 3 = W.
- fwd_d_rt  output  2  D rt source, same encoding.
- fwd_e_rs  output  2  E rs source: 0 = D/E register, 1 = M, 2 = W.
- fwd_e_rt  output  2  E rt source, same encoding.
- fwd_m_rt  output  1  M store data: 0 = E/M register, 1 = W.

Behaviour:
Per-stage state (E, M, W):
- E and M hold: wa, we, tnew, rs, rt.
- W holds: wa, we.
- Reset clears every we, wa, tnew, rs and rt to 0, so all forwarding outputs read 0 and stall reads 0 in the cycle after reset.

Matching:
- A stage "matches" operand r when: stage.we = 1, stage.wa = r, and r != 0.
- Register $0 never matches, never forwards and never stalls.

Stall (combinational, current cycle):
- For each operand r in {rs, rt} with tuse != TUSE_NONE, stall = 1 if either:
  - E matches r and E.tnew > tuse, or
  - M matches r and M.tnew > tuse.
- W never causes a stall.

D forwarding, priority E > M > W > RF:
- Select E only if E matches and E.tnew = 0.
- Select M only if M matches and M.tnew = 0.
- Select W if W matches.
- A match whose tnew is not 0 blocks all older stages. Output is 0; stall covers it when the operand is needed. Stale data from an older stage is never selected.
- If tuse = TUSE_NONE, the select still reflects the match rule (harmless).

E forwarding, priority M > W > 0:
- Same rules, applied to E.rs and E.rt against the M and W stages.

M forwarding:
- fwd_m_rt = 1 iff W matches M.rt.

Clock-edge update:
- W <= M.
- M <= E, with tnew = max(E.tnew − 1, 0).
- If stall = 0: E <= {d_wa, d_we, d_tnew, d_rs, d_rt}.
- If stall = 1: E <= bubble (we = 0, wa = 0, tnew = 0, rs = 0, rt = 0). D inputs are held externally and re-evaluated next cycle.

Latency and boundary rules:
- Latency: all outputs are combinational from current state plus D inputs; there are no registered outputs.
- Back-to-back stalls: a load followed by a branch on its result stalls 2 cycles (E.tnew = 2, then M.tnew = 1), then forwards from W.
- Reset asserted mid-stall: next cycle all stage state is cleared and stall = 0, regardless of D inputs.
- Tnew saturates at 0 and never underflows.

Test Plan:
- Reset: assert reset 2 cycles with d_we = 1 → stall = 0 and every fwd_* = 0 on the cycle after deassertion.
- ALU→ALU: issue addu $3 (tnew 1), then addu reading $3 (tuse 1) → no stall; next cycle fwd_e_rs = 1 (from M); one cycle later an instruction reading $3 in E gets fwd_e_rs = 2 (from W).
- Load-use: lw $5 (tnew 2), then beq on $5 (tuse 0) → stall = 1 for 2 cycles, E holds bubbles, then fwd_d_rs = 3 with stall = 0.
- Priority: lui $4 (tnew 0), then ori $4 (tnew 1), then a reader of $4 (tuse 1) in D → fwd_d_rs = 0 (M blocked by E.tnew = 1) with stall = 0; next cycle in E, fwd_e_rs = 1.
- $0 writes: instruction writing $0, then a reader of $0 with tuse 0 → stall = 0, fwd_d_rs = 0.
- Store data: lw $6, then sw with rt = $6 (tuse 2) → no stall; at sw in M, fwd_m_rt = 1.
